rx_block_assembler: RTL and testbench

RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

---
 rtl/rx_block_assembler.sv | 187 ++++++++++++++++++
 tb/tb_rx_block_assembler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_assembler.sv
// rx_block_assembler
// Packs the UART byte stream into 128-bit plaintext blocks. The first byte of a
// block lands in bits [127:120]. Completed blocks go into a show-ahead FIFO that
// feeds the AES core.
// Optional feature: define RX_BLOCK_TIMEOUT_EN to discard a partial block after
// TIMEOUT_CYCLES idle clocks. Without it, timeout_err is tied low and a partial
// block is held indefinitely.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | no partial block held, byte_count == 0
// S_ASSEMBLE | 1..15 bytes of the current block are held
module rx_block_assembler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_byte_valid,
  input  logic [7:0]   rx_byte,
  output logic [127:0] text_out,
  output logic         text_valid,
  input  logic         text_ready,
  output logic [3:0]   byte_count,
  output logic         buffer_full,
  output logic         overflow,
  output logic         timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_ASSEMBLE = 2'b01
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     byte_count_q, byte_count_d;
  // Holds the first 15 bytes of the block. The newest byte is in the low lane.
  logic [119:0]   partial_q, partial_d;
  logic           push_req;
  logic           tmo_hit;

  logic [127:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           overflow_q;
  logic           fifo_full;
  logic           pop;
  logic           push_ok;

`ifdef RX_BLOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]  idle_q, idle_d;
  logic           timeout_q;

  // The timeout fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
  // A byte in that same cycle takes priority, so the match is qualified with !rx_byte_valid.
  always_comb begin
    tmo_hit = (state_q == S_ASSEMBLE) && !rx_byte_valid && (idle_q == TO_LAST);
    idle_d  = '0;
    if (state_q == S_ASSEMBLE && !rx_byte_valid && !tmo_hit) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter and timeout pulse register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= tmo_hit;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, byte packing and block-complete request
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    partial_d    = partial_q;
    push_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_byte_valid) begin
          state_d      = S_ASSEMBLE;
          byte_count_d = 4'd1;
          partial_d    = {partial_q[111:0], rx_byte};
        end
      end
      S_ASSEMBLE: begin
        if (rx_byte_valid) begin
          partial_d = {partial_q[111:0], rx_byte};
          if (byte_count_q == 4'd15) begin
            push_req     = 1'b1;
            byte_count_d = 4'd0;
            state_d      = S_IDLE;
          end else begin
            byte_count_d = byte_count_q + 4'd1;
          end
        end else if (tmo_hit) begin
          byte_count_d = 4'd0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        byte_count_d = 4'd0;
      end
    endcase
  end

  // Partial block datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_count_q <= 4'd0;
      partial_q    <= '0;
    end else begin
      byte_count_q <= byte_count_d;
      partial_q    <= partial_d;
    end
  end

  assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop       = (cnt_q != '0) && text_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot that the incoming block takes.
  assign push_ok   = push_req && (!fifo_full || pop);

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      overflow_q <= push_req && !push_ok;
    end
  end

  // FIFO storage. There is no reset because occupancy alone decides whether an entry is valid.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) begin
      mem_q[wr_ptr_q] <= {partial_q, rx_byte};
    end
  end

  assign text_valid  = (cnt_q != '0);
  assign text_out    = text_valid ? mem_q[rd_ptr_q] : '0;
  assign byte_count  = byte_count_q;
  assign buffer_full = fifo_full;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Randomised and directed bench for rx_block_assembler. A queue-based reference
// model predicts the accepted blocks and the status outputs. A negedge monitor
// compares the DUT against the model every cycle and pops expected blocks on each handshake.
module tb_rx_block_assembler;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic         clk;
  logic         reset_n;
  logic         rx_byte_valid;
  logic [7:0]   rx_byte;
  logic [127:0] text_out;
  logic         text_valid;
  logic         text_ready;
  logic [3:0]   byte_count;
  logic         buffer_full;
  logic         overflow;
  logic         timeout_err;

  rx_block_assembler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .text_out     (text_out),
    .text_valid   (text_valid),
    .text_ready   (text_ready),
    .byte_count   (byte_count),
    .buffer_full  (buffer_full),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [7:0]   m_partial[$];
  logic [127:0] exp_q[$];
  int           m_occ   = 0;
  int           m_idle  = 0;
  bit           m_ovf   = 0;
  bit           m_tmo   = 0;
  int           ovf_seen = 0;
  int           tmo_seen = 0;
  int           pops     = 0;
  logic [127:0] last_pop = '0;

  // Model: one step per clock edge, driven only by the bench's own inputs
  always @(posedge clk) begin
    logic [127:0] blk;
    bit           do_pop;
    if (!reset_n) begin
      m_partial.delete();
      exp_q.delete();
      m_occ = 0; m_idle = 0; m_ovf = 0; m_tmo = 0;
    end else begin
      do_pop = (m_occ > 0) && text_ready;
      m_ovf  = 0;
      m_tmo  = 0;
      if (rx_byte_valid) begin
        m_idle = 0;
        m_partial.push_back(rx_byte);
        if (m_partial.size() == 16) begin
          blk = '0;
          foreach (m_partial[i]) blk = {blk[119:0], m_partial[i]};
          m_partial.delete();
          if (m_occ < DEPTH || do_pop) begin
            exp_q.push_back(blk);
            m_occ++;
          end else begin
            m_ovf = 1;
          end
        end
      end else if (m_partial.size() > 0) begin
`ifdef RX_BLOCK_TIMEOUT_EN
        m_idle++;
        if (m_idle == TMO) begin
          m_partial.delete();
          m_idle = 0;
          m_tmo  = 1;
        end
`endif
      end
      if (do_pop) m_occ--;
    end
  end

  // Monitor: compare the status outputs every cycle, and the block on each handshake
  always @(negedge clk) begin
    chk("text_valid", 128'(text_valid), 128'(m_occ > 0));
    chk("buffer_full", 128'(buffer_full), 128'(m_occ == DEPTH));
    chk("byte_count", 128'(byte_count), 128'(m_partial.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("timeout_err", 128'(timeout_err), 128'(m_tmo));
    if (overflow) ovf_seen++;
    if (timeout_err) tmo_seen++;
    if (!text_valid) chk("text_out_idle_zero", text_out, 128'h0);
    if (text_valid && text_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", text_out, 128'hx);
      end else begin
        chk("block_data", text_out, exp_q.pop_front());
      end
      pops++;
      last_pop = text_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    text_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    text_ready = 1'b0;
  endtask

  int ovf0, pops0;

  initial begin
    reset_n       = 1'b0;
    rx_byte_valid = 1'b0;
    rx_byte       = 8'h00;
    text_ready    = 1'b0;
    repeat (3) tick();
    chk("reset_text_valid", 128'(text_valid), 128'h0);
    chk("reset_text_out", text_out, 128'h0);
    chk("reset_byte_count", 128'(byte_count), 128'h0);
    reset_n = 1'b1;
    tick();

    // Single block, 1-cycle latency to text_valid
    send_block(8'h00);
    chk("blk_latency_valid", 128'(text_valid), 128'h1);
    chk("blk_value", text_out, 128'h000102030405060708090A0B0C0D0E0F);
    chk("blk_byte_count", 128'(byte_count), 128'h0);
    drain();

    // Five blocks into a depth-4 FIFO with no reads
    ovf0 = ovf_seen;
    pops0 = pops;
    for (int b = 0; b < 4; b++) send_block(8'(8'h10 * (b + 1)));
    chk("full_after_4", 128'(buffer_full), 128'h1);
    send_block(8'h50);
    tick();
    chk("overflow_once", 128'(ovf_seen - ovf0), 128'h1);
    drain();
    chk("pops_after_overflow", 128'(pops - pops0), 128'h4);
    chk("last_of_4", last_pop, 128'h404142434445464748494A4B4C4D4E4F);

    // Full FIFO, 16th byte coincides with a pop
    ovf0 = ovf_seen;
    for (int b = 0; b < 4; b++) send_block(8'(8'h10 * (b + 1)));
    for (int i = 0; i < 15; i++) send_byte(8'h60 + 8'(i));
    text_ready = 1'b1;
    send_byte(8'h6F);
    text_ready = 1'b0;
    chk("simul_push_pop_full", 128'(buffer_full), 128'h1);
    tick();
    chk("simul_no_overflow", 128'(ovf_seen - ovf0), 128'h0);
    pops0 = pops;
    drain();
    chk("simul_pops", 128'(pops - pops0), 128'h4);
    chk("simul_last_block", last_pop, 128'h606162636465666768696A6B6C6D6E6F);

    // Idle after a partial block
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
`ifdef RX_BLOCK_TIMEOUT_EN
    repeat (TMO + 3) tick();
    chk("timeout_pulse", 128'(tmo_seen), 128'h1);
    chk("timeout_count", 128'(byte_count), 128'h0);
    pops0 = pops;
    send_block(8'hD0);
    drain();
    chk("post_timeout_block", last_pop, 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);
`else
    repeat (3 * TMO) tick();
    chk("no_timeout_held", 128'(byte_count), 128'h7);
    chk("no_timeout_pulse", 128'(tmo_seen), 128'h0);
    pops0 = pops;
    for (int i = 7; i < 16; i++) send_byte(8'hC0 + 8'(i));
    drain();
    chk("held_partial_block", last_pop, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
`endif
    chk("one_block_after_idle", 128'(pops - pops0), 128'h1);

    // Reset mid-block with a byte strobe in the reset cycle
    for (int i = 0; i < 9; i++) send_byte(8'h90 + 8'(i));
    rx_byte_valid = 1'b1;
    rx_byte       = 8'h99;
    do_reset();
    rx_byte_valid = 1'b0;
    chk("reset_mid_count", 128'(byte_count), 128'h0);
    pops0 = pops;
    send_block(8'hA0);
    drain();
    chk("post_reset_pops", 128'(pops - pops0), 128'h1);
    chk("post_reset_block", last_pop, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // Randomised traffic with random back-pressure and one reset
    for (int c = 0; c < 1500; c++) begin
      text_ready    = 1'($urandom_range(0, 1));
      rx_byte_valid = ($urandom_range(0, 3) != 0);
      rx_byte       = 8'($urandom);
      reset_n       = (c != 700);
      tick();
    end
    rx_byte_valid = 1'b0;
    reset_n       = 1'b1;
    drain();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
